// File: rtl/mem_resp_pkg.sv
// Shared types, parameter limits and address legality for the
// multi-cycle data-memory responder.
package mem_resp_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   localparam int unsigned MIN_DEPTH   = 4;
   localparam int unsigned MIN_LATENCY = 1;

   function automatic logic depth_ok(input int unsigned depth);
      return (depth >= MIN_DEPTH) && ((depth & (depth - 1)) == 0);
   endfunction

   function automatic logic latency_ok(input int unsigned latency);
      return latency >= MIN_LATENCY;
   endfunction

   // Word aligned and inside the array; the upper address bits count too.
   function automatic logic addr_legal(
      input logic [31:0] addr,
      input int unsigned depth
   );
      return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < depth);
   endfunction

endpackage

// File: rtl/data_mem_responder_array.sv
// Single-port word array; its read register doubles as the
// responder's rdata output, cleared on reset or on a faulted access.
module dm_array #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          we,
   input  logic          re,
   input  logic          clr,
   input  logic [AW-1:0] idx,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   // Storage is deliberately not reset; only the read register is.
   always_ff @(posedge clk_i) begin
      if (we) begin
         mem[idx] <= wdata;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rdata <= '0;
      end else if (clr) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[idx];
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data-memory responder: one request at a time, completed
// LATENCY cycles after accept with a one-cycle ack and a stall output.
module data_mem_responder
   import mem_resp_pkg::*;
#(
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned LATENCY = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        ready_o,
   output logic        ack_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   output logic        stall_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(LATENCY) + 1;

   if (!depth_ok(DEPTH) || !latency_ok(LATENCY)) begin : g_bad_param
      $error("data_mem_responder: illegal DEPTH or LATENCY");
   end

   state_t        state;
   logic [CW-1:0] cnt;
   logic          we_q;
   logic [31:0]   addr_q;
   logic [31:0]   wdata_q;
   logic          fire;
   logic          legal;

   assign legal   = addr_legal(addr_q, DEPTH);
   assign fire    = (state == BUSY) && (cnt == '0);
   assign ready_o = (state == IDLE);
   assign stall_o = req_i & ~ack_o;

   dm_array #(
      .DEPTH (DEPTH)
   ) u_array (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .we    (fire & we_q & legal),
      .re    (fire & ~we_q & legal),
      .clr   (fire & ~legal),
      .idx   (addr_q[AW+1:2]),
      .wdata (wdata_q),
      .rdata (rdata_o)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= IDLE;
         cnt     <= '0;
         ack_o   <= 1'b0;
         err_o   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               ack_o <= 1'b0;
               if (req_i) begin
                  we_q    <= we_i;
                  addr_q  <= addr_i;
                  wdata_q <= wdata_i;
                  cnt     <= CW'(LATENCY - 1);
                  state   <= BUSY;
               end
            end
            BUSY: begin
               // The access itself happens in dm_array on this same edge.
               if (cnt == '0) begin
                  ack_o <= 1'b1;
                  err_o <= ~legal;
                  state <= DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               ack_o <= 1'b0;
               state <= IDLE;
            end
            default: begin
               ack_o <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a LATENCY=4 and a
// LATENCY=1 instance driven with directed load/store vectors.
module tb_data_mem_responder;

   typedef struct packed {
      logic [31:0] rd;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst   [2];
   logic        req   [2];
   logic        we    [2];
   logic [31:0] addr  [2];
   logic [31:0] wdata [2];
   logic        ready [2];
   logic        ack   [2];
   logic [31:0] rdata [2];
   logic        err   [2];
   logic        stall [2];

   exp_t q0[$];
   exp_t q1[$];
   int   checks   = 0;
   int   failures = 0;
   int   edge_n   = 0;

   always #5 clk = ~clk;

   always @(posedge clk) edge_n <= edge_n + 1;

   data_mem_responder #(
      .DEPTH   (256),
      .LATENCY (4)
   ) u_l4 (
      .clk_i   (clk),
      .rst_i   (rst[0]),
      .req_i   (req[0]),
      .we_i    (we[0]),
      .addr_i  (addr[0]),
      .wdata_i (wdata[0]),
      .ready_o (ready[0]),
      .ack_o   (ack[0]),
      .rdata_o (rdata[0]),
      .err_o   (err[0]),
      .stall_o (stall[0])
   );

   data_mem_responder #(
      .DEPTH   (256),
      .LATENCY (1)
   ) u_l1 (
      .clk_i   (clk),
      .rst_i   (rst[1]),
      .req_i   (req[1]),
      .we_i    (we[1]),
      .addr_i  (addr[1]),
      .wdata_i (wdata[1]),
      .ready_o (ready[1]),
      .ack_o   (ack[1]),
      .rdata_o (rdata[1]),
      .err_o   (err[1]),
      .stall_o (stall[1])
   );

   function automatic int lat_of(input int i);
      return (i == 0) ? 4 : 1;
   endfunction

   task automatic cmp(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic mon_one(input int i);
      exp_t e;
      if (i == 0 && q0.size() == 0 || i == 1 && q1.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL unexpected_ack_d%0d actual=1 required=0", i);
      end else begin
         e = (i == 0) ? q0.pop_front() : q1.pop_front();
         cmp($sformatf("rdata_d%0d", i), rdata[i], e.rd);
         cmp($sformatf("err_d%0d", i), {31'b0, err[i]}, {31'b0, e.err});
      end
   endtask

   // One request: push the expectation, wait for ack, check timing.
   task automatic txn(input int i, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] erd,
                      input logic eer, input bit hold,
                      output int acc_edge, output int stall_hi);
      exp_t e;
      int   lat;
      bit   acc;
      bit   got;
      bit   stall_ok;
      we[i]    = w;
      addr[i]  = a;
      wdata[i] = d;
      req[i]   = 1'b1;
      e.rd     = erd;
      e.err    = eer;
      if (i == 0) q0.push_back(e);
      else q1.push_back(e);
      lat      = 0;
      got      = 0;
      stall_ok = 1;
      stall_hi = 0;
      acc_edge = 0;
      #1;
      acc = ready[i];
      if (acc) acc_edge = edge_n + 1;
      if (stall[i]) stall_hi++;
      else stall_ok = 0;
      for (int c = 0; c < 40 && !got; c++) begin
         @(negedge clk);
         if (acc) begin
            lat++;
         end else if (ready[i]) begin
            acc      = 1;
            acc_edge = edge_n + 1;
         end
         if (ack[i]) got = 1;
         else if (stall[i]) stall_hi++;
         else stall_ok = 0;
      end
      if (!got) begin
         checks++;
         failures++;
         $display("FAIL ack_timeout_d%0d actual=none required=ack", i);
      end else begin
         cmp($sformatf("ack_latency_d%0d", i), 32'(lat - 1),
             32'(lat_of(i)));
         cmp($sformatf("stall_in_ack_d%0d", i), {31'b0, stall[i]}, 0);
         cmp($sformatf("stall_while_wait_d%0d", i), {31'b0, stall_ok},
             1);
         if (!hold) req[i] = 1'b0;
         @(negedge clk);
         cmp($sformatf("ack_width_d%0d", i), {31'b0, ack[i]}, 0);
      end
   endtask

   initial begin
      int  ae;
      int  sh;
      int  acc_a;
      int  acc_b;
      int  acc_c;
      bit  seen;

      fork
         forever begin
            @(negedge clk);
            if (ack[0] === 1'b1) mon_one(0);
            if (ack[1] === 1'b1) mon_one(1);
         end
      join_none

      for (int i = 0; i < 2; i++) begin
         rst[i]   = 1'b1;
         req[i]   = 1'b0;
         we[i]    = 1'b0;
         addr[i]  = '0;
         wdata[i] = '0;
      end
      repeat (2) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         cmp($sformatf("reset_ready_d%0d", i), {31'b0, ready[i]}, 1);
         cmp($sformatf("reset_ack_d%0d", i), {31'b0, ack[i]}, 0);
         cmp($sformatf("reset_rdata_d%0d", i), rdata[i], 0);
         cmp($sformatf("reset_err_d%0d", i), {31'b0, err[i]}, 0);
         rst[i] = 1'b0;
      end
      @(negedge clk);
      cmp("idle_stall_d0", {31'b0, stall[0]}, 0);

      txn(0, 1, 32'h20, 32'h2020_2020, 32'h0, 0, 0, ae, sh);

      // Reset two edges into a store: nothing may complete or be written.
      we[0]    = 1'b1;
      addr[0]  = 32'h20;
      wdata[0] = 32'h1111_1111;
      req[0]   = 1'b1;
      repeat (3) @(negedge clk);
      rst[0] = 1'b1;
      req[0] = 1'b0;
      #1;
      cmp("abort_ready", {31'b0, ready[0]}, 1);
      cmp("abort_rdata", rdata[0], 0);
      cmp("abort_err", {31'b0, err[0]}, 0);
      @(negedge clk);
      rst[0] = 1'b0;
      seen   = 0;
      repeat (8) begin
         @(negedge clk);
         if (ack[0]) seen = 1;
      end
      cmp("abort_no_ack", {31'b0, seen}, 0);

      txn(0, 0, 32'h20, 32'h0, 32'h2020_2020, 0, 0, ae, sh);
      txn(0, 1, 32'h10, 32'hDEAD_BEEF, 32'h2020_2020, 0, 0, ae, sh);
      txn(0, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, 0, ae, sh);
      txn(0, 0, 32'h13, 32'h0, 32'h0, 1, 0, ae, sh);
      txn(0, 1, 32'h12, 32'hFFFF_FFFF, 32'h0, 1, 0, ae, sh);
      txn(0, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, 0, ae, sh);
      txn(0, 0, 32'h400, 32'h0, 32'h0, 1, 0, ae, sh);
      txn(0, 1, 32'h3FC, 32'hA5A5_A5A5, 32'h0, 0, 0, ae, sh);
      txn(0, 0, 32'h3FC, 32'h0, 32'hA5A5_A5A5, 0, 0, ae, sh);

      txn(0, 1, 32'h0, 32'h1000_0000, 32'hA5A5_A5A5, 0, 1, acc_a, sh);
      txn(0, 1, 32'h4, 32'h1000_0004, 32'hA5A5_A5A5, 0, 1, acc_b, sh);
      txn(0, 1, 32'h8, 32'h1000_0008, 32'hA5A5_A5A5, 0, 0, acc_c, sh);
      cmp("b2b_gap_1", 32'(acc_b - acc_a), 6);
      cmp("b2b_gap_2", 32'(acc_c - acc_b), 6);
      txn(0, 0, 32'h0, 32'h0, 32'h1000_0000, 0, 0, ae, sh);
      txn(0, 0, 32'h4, 32'h0, 32'h1000_0004, 0, 0, ae, sh);
      txn(0, 0, 32'h8, 32'h0, 32'h1000_0008, 0, 0, ae, sh);

      txn(1, 1, 32'h0, 32'hCAFE_F00D, 32'h0, 0, 0, ae, sh);
      txn(1, 0, 32'h0, 32'h0, 32'hCAFE_F00D, 0, 0, ae, sh);
      cmp("l1_stall_cycles", 32'(sh), 2);

      repeat (3) @(negedge clk);
      cmp("queue_empty_d0", 32'(q0.size()), 0);
      cmp("queue_empty_d1", 32'(q1.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
